// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit that owns the HI/LO pair.
// Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle
// on operand magnitudes, then fixes up signs and commits HI/LO in a final cycle.
// Also services mfhi/mflo/mthi/mtlo and stalls HI/LO users while busy.

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MTLO = 6'h13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_isDiv;
    logic             r_signA;
    logic             r_signB;
    logic [WIDTH-1:0] r_rawA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_accHi;
    logic [WIDTH-1:0] r_accLo;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_isMulDiv;
    logic             w_isMove;
    logic             w_hiloOp;
    logic             w_signA;
    logic             w_signB;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH-1:0] w_divDiff;
    logic             w_divGe;
    logic [WIDTH-1:0] w_stepHi;
    logic [WIDTH-1:0] w_stepLo;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;

    // Decode the instruction class and form operand magnitudes for signed ops.
    always_comb begin
        w_isMulDiv = op_valid && (Funct[5:2] == 4'b0110);
        w_isMove   = op_valid && (Funct[5:2] == 4'b0100);
        w_hiloOp   = w_isMulDiv || w_isMove;
        w_signA    = ~Funct[0] & rs_data[WIDTH-1];
        w_signB    = ~Funct[0] & rt_data[WIDTH-1];
        w_absA     = w_signA ? (~rs_data + 1'b1) : rs_data;
        w_absB     = w_signB ? (~rt_data + 1'b1) : rt_data;
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        w_mulSum   = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : {(WIDTH+1){1'b0}});
        w_divShift = {r_accHi, r_accLo[WIDTH-1]};
        w_divGe    = (w_divShift >= {1'b0, r_opB});
        w_divDiff  = w_divShift[WIDTH-1:0] - r_opB;
        if (r_isDiv) begin
            w_stepHi = w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
            w_stepLo = {r_accLo[WIDTH-2:0], w_divGe};
        end else begin
            w_stepHi = w_mulSum[WIDTH:1];
            w_stepLo = {w_mulSum[0], r_accLo[WIDTH-1:1]};
        end
    end

    // Sign correction and the divide-by-zero result, applied in the fix cycle.
    always_comb begin
        w_prod    = {r_accHi, r_accLo};
        w_prodFix = (r_signA ^ r_signB) ? (~w_prod + 1'b1) : w_prod;
        w_quot    = (r_signA ^ r_signB) ? (~r_accLo + 1'b1) : r_accLo;
        w_rem     = r_signA ? (~r_accHi + 1'b1) : r_accHi;
        if (r_opB == '0) begin
            w_quot = '1;
            w_rem  = r_rawA;
        end
        if (r_isDiv) begin
            w_resHi = w_rem;
            w_resLo = w_quot;
        end else begin
            w_resHi = w_prodFix[2*WIDTH-1:WIDTH];
            w_resLo = w_prodFix[WIDTH-1:0];
        end
    end

    // Sequencer FSM: accept in IDLE, iterate in RUN, commit HI/LO in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_isDiv <= 1'b0;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_rawA  <= '0;
            r_opB   <= '0;
            r_accHi <= '0;
            r_accLo <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (!flush) begin
                        if (w_isMulDiv) begin
                            r_isDiv <= Funct[1];
                            r_signA <= w_signA;
                            r_signB <= w_signB;
                            r_rawA  <= rs_data;
                            r_opB   <= w_absB;
                            r_accHi <= '0;
                            r_accLo <= w_absA;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else if (w_isMove) begin
                            if (Funct == F_MTHI) r_hi <= rs_data;
                            if (Funct == F_MTLO) r_lo <= rs_data;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_accHi <= w_stepHi;
                        r_accLo <= w_stepLo;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_COUNT) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi <= w_resHi;
                        r_lo <= w_resLo;
                    end
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall = w_hiloOp && (r_state != S_IDLE);
    assign busy  = r_busy;
    assign done  = r_done & ~flush;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: self-checking bench for muldiv_sequencer.
// Table vectors, hand-written multi-cycle corner sequences and random ops
// compared against a plain-arithmetic model of HI/LO.

module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  Funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdlHi = '0;
    logic [31:0] mdlLo = '0;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .Funct    (Funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Move one cycle forward and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic fl);
        op_valid = v;
        Funct    = f;
        rs_data  = a;
        rt_data  = b;
        flush    = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // HI/LO behaviour from the instruction definitions, using wide arithmetic.
    function automatic void refModel(input logic [5:0] f, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] hiIn,
                                     input logic [31:0] loIn,
                                     output logic [31:0] hiOut, output logic [31:0] loOut);
        longint      sp;
        logic [63:0] up;
        int          sq;
        int          sr;
        hiOut = hiIn;
        loOut = loIn;
        case (f)
            F_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hiOut, loOut} = sp;
            end
            F_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {hiOut, loOut} = up;
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    loOut = '1;
                    hiOut = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    loOut = 32'h8000_0000;
                    hiOut = 32'd0;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    loOut = sq;
                    hiOut = sr;
                end
            end
            F_DIVU: begin
                if (b == 32'd0) begin
                    loOut = '1;
                    hiOut = a;
                end else begin
                    loOut = a / b;
                    hiOut = a % b;
                end
            end
            F_MTHI: hiOut = a;
            F_MTLO: loOut = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present a mul/div for one edge, then drop it.
    task automatic issueOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, f, a, b, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
    endtask

    // Called on the cycle after acceptance; checks latency and committed result.
    task automatic finishOp(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
        int cyc;
        cyc = 1;
        checkOutput({name, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checkOutput({name, "_latency"}, cyc, 32'd33);
        tick();
        checkOutput({name, "_hi"}, hi, expHi);
        checkOutput({name, "_lo"}, lo, expLo);
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
        mdlHi = expHi;
        mdlLo = expLo;
    endtask

    task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        issueOp(f, a, b);
        finishOp(name, expHi, expLo);
    endtask

    task automatic watchNoDone(input string name);
        logic seen;
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            tick();
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
        applyStimulus(1'b1, F_MTHI, h, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, F_MTLO, l, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        mdlHi = h;
        mdlLo = l;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        int          cnt;

        vecs[0]  = '{F_MULT,  32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{F_MULT,  32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
        vecs[6]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[10] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[11] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        // Reset state, with an mfhi presented so stall is exercised.
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo);
        end

        // Reset in the middle of a multiply discards it.
        writeHiLo(32'd5, 32'd9);
        issueOp(F_MULT, 32'd7, 32'd6);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
        checkOutput("midReset_hi", hi, 32'd0);
        checkOutput("midReset_lo", lo, 32'd0);
        checkOutput("midReset_busy", 32'(busy), 32'd0);
        checkOutput("midReset_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        mdlHi = 32'd0;
        mdlLo = 32'd0;
        watchNoDone("midReset_noDone");

        // mtlo in IDLE writes LO at the next edge without stalling.
        applyStimulus(1'b1, F_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        checkOutput("mtlo_stall", 32'(stall), 32'd0);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        checkOutput("mtlo_lo", lo, 32'hDEAD_BEEF);
        checkOutput("mtlo_hi", hi, mdlHi);
        mdlLo = 32'hDEAD_BEEF;

        // mthi with flush in IDLE is dropped.
        applyStimulus(1'b1, F_MTHI, 32'h0000_1234, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        checkOutput("flushMthi_hi", hi, mdlHi);

        // Flush on RUN cycle 10 of a divide.
        writeHiLo(32'hAAAA_5555, 32'h1234_5678);
        issueOp(F_DIV, 32'd100, 32'd3);
        repeat (9) tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        checkOutput("flushRun_busy", 32'(busy), 32'd0);
        checkOutput("flushRun_hi", hi, 32'hAAAA_5555);
        checkOutput("flushRun_lo", lo, 32'h1234_5678);
        watchNoDone("flushRun_noDone");

        // Flush during the FIX cycle suppresses done and the commit.
        issueOp(F_MULT, 32'd3, 32'd5);
        cnt = 1;
        while (done !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("flushFix_doneSeen", 32'(done), 32'd1);
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("flushFix_doneMasked", 32'(done), 32'd0);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        checkOutput("flushFix_busy", 32'(busy), 32'd0);
        checkOutput("flushFix_hi", hi, 32'hAAAA_5555);
        checkOutput("flushFix_lo", lo, 32'h1234_5678);

        // mfhi presented right after a multiply stalls for 33 cycles.
        a = 32'h0001_2345;
        b = 32'hFFFF_0F0F;
        refModel(F_MULT, a, b, mdlHi, mdlLo, eh, el);
        issueOp(F_MULT, a, b);
        applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("mfhiStall_cycles", cnt, 32'd33);
        checkOutput("mfhiStall_hi", hi, eh);
        checkOutput("mfhiStall_lo", lo, el);
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        mdlHi = eh;
        mdlLo = el;

        // A second multiply presented while busy waits, then runs.
        issueOp(F_MULT, 32'd2, 32'd3);
        applyStimulus(1'b1, F_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0);
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("b2b_stallCycles", cnt, 32'd33);
        checkOutput("b2b_firstLo", lo, 32'd6);
        tick();
        applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
        refModel(F_MULT, 32'h0001_0000, 32'h0003_0000, 32'd0, 32'd6, eh, el);
        finishOp("b2b", eh, el);

        // Random ops against the model.
        for (int i = 0; i < 30; i++) begin
            cnt = $urandom_range(0, 5);
            a = pickOperand();
            b = pickOperand();
            if (cnt < 4) begin
                f = F_MULT + 6'(cnt);
                refModel(f, a, b, mdlHi, mdlLo, eh, el);
                runOp($sformatf("rand%0d_f%02h", i, f), f, a, b, eh, el);
            end else begin
                f = (cnt == 4) ? F_MTHI : F_MTLO;
                refModel(f, a, b, mdlHi, mdlLo, eh, el);
                applyStimulus(1'b1, f, a, b, 1'b0);
                tick();
                applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
                checkOutput($sformatf("rand%0d_mvHi", i), hi, eh);
                checkOutput($sformatf("rand%0d_mvLo", i), lo, el);
                mdlHi = eh;
                mdlLo = el;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
